// File: rtl/mmss_clock.sv
// MM:SS elapsed-time counter driven by a one-second tick, with run/pause button,
// active-low 7-segment outputs and a one-cycle pulse on each minute rollover.
module mmss_clock #(
    parameter bit RUN_AT_RESET = 1'b1,
    parameter int MAX_MIN      = 59
) (
    input  logic       CLOCK_50,
    input  logic       KEY,
    input  logic       tick,
    input  logic       run_btn,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic       LEDG,
    output logic       min_pulse
);

    typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} state_t;

    localparam logic [3:0] MAX_MT = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_MU = 4'(MAX_MIN % 10);

    state_t     state_q, state_d;
    logic       led_q, pulse_q, pulse_d;
    logic       tick_d_q;
    logic       b1_q, b2_q, b3_q;
    logic [3:0] s_u_q, s_t_q, m_u_q, m_t_q;
    logic [3:0] s_u_d, s_t_d, m_u_d, m_t_d;
    logic       tick_rise, btn_rise, count_en;

    assign tick_rise = tick & ~tick_d_q;
    assign btn_rise  = b2_q & ~b3_q;
    // The count decision uses the state before any same-edge toggle.
    assign count_en  = tick_rise && (state_q == RUNNING);

    always_comb begin
        s_u_d   = s_u_q;
        s_t_d   = s_t_q;
        m_u_d   = m_u_q;
        m_t_d   = m_t_q;
        pulse_d = 1'b0;
        state_d = state_q;
        if (btn_rise)
            state_d = (state_q == RUNNING) ? STOPPED : RUNNING;
        if (count_en) begin
            if (s_u_q != 4'd9) begin
                s_u_d = s_u_q + 4'd1;
            end else begin
                s_u_d = 4'd0;
                if (s_t_q != 4'd5) begin
                    s_t_d = s_t_q + 4'd1;
                end else begin
                    s_t_d   = 4'd0;
                    pulse_d = 1'b1;
                    if (m_t_q == MAX_MT && m_u_q == MAX_MU) begin
                        m_u_d = 4'd0;
                        m_t_d = 4'd0;
                    end else if (m_u_q == 4'd9) begin
                        m_u_d = 4'd0;
                        m_t_d = m_t_q + 4'd1;
                    end else begin
                        m_u_d = m_u_q + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (KEY) begin
            state_q  <= RUN_AT_RESET ? RUNNING : STOPPED;
            led_q    <= RUN_AT_RESET;
            pulse_q  <= 1'b0;
            tick_d_q <= 1'b0;
            b1_q     <= 1'b0;
            b2_q     <= 1'b0;
            b3_q     <= 1'b0;
            s_u_q    <= 4'd0;
            s_t_q    <= 4'd0;
            m_u_q    <= 4'd0;
            m_t_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            led_q    <= (state_d == RUNNING);
            pulse_q  <= pulse_d;
            tick_d_q <= tick;
            b1_q     <= run_btn;
            b2_q     <= b1_q;
            b3_q     <= b2_q;
            s_u_q    <= s_u_d;
            s_t_q    <= s_t_d;
            m_u_q    <= m_u_d;
            m_t_q    <= m_t_d;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    logic [3:0] digit [4];
    logic [6:0] hex_w [4];

    assign digit[0] = s_u_q;
    assign digit[1] = s_t_q;
    assign digit[2] = m_u_q;
    assign digit[3] = m_t_q;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dec
        assign hex_w[gi] = seg7(digit[gi]);
    end

    assign HEX0      = hex_w[0];
    assign HEX1      = hex_w[1];
    assign HEX2      = hex_w[2];
    assign HEX3      = hex_w[3];
    assign LEDG      = led_q;
    assign min_pulse = pulse_q;

endmodule

// File: tb/tb_mmss_clock.sv
// Scoreboard bench for mmss_clock: a behavioural MM:SS model pushes expected
// display/LED/pulse values as stimulus is driven; they are popped after the edge.
module tb_mmss_clock;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       key, tick, run_btn;
    logic [6:0] hex0, hex1, hex2, hex3;
    logic       ledg, min_pulse;

    logic       key2, tick2, btn2;
    logic [6:0] h2_0, h2_1, h2_2, h2_3;
    logic       ledg2, mp2;

    mmss_clock #(.RUN_AT_RESET(1'b1), .MAX_MIN(59)) dut (
        .CLOCK_50(clk), .KEY(key), .tick(tick), .run_btn(run_btn),
        .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3),
        .LEDG(ledg), .min_pulse(min_pulse)
    );

    mmss_clock #(.RUN_AT_RESET(1'b0), .MAX_MIN(59)) dut_stop (
        .CLOCK_50(clk), .KEY(key2), .tick(tick2), .run_btn(btn2),
        .HEX0(h2_0), .HEX1(h2_1), .HEX2(h2_2), .HEX3(h2_3),
        .LEDG(ledg2), .min_pulse(mp2)
    );

    typedef struct packed {
        logic [27:0] hex;
        logic        led;
        logic        pulse;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    int mm, ss;
    bit run, exp_pulse;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [27:0] hex_of(input int m, input int s);
        return {seg(m / 10), seg(m % 10), seg(s / 10), seg(s % 10)};
    endfunction

    task automatic push_exp(input string t);
        exp_t e;
        e.hex   = hex_of(mm, ss);
        e.led   = run;
        e.pulse = exp_pulse;
        sb_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic pop_cmp();
        exp_t  e;
        string t;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        chk({t, ".hex"},   {hex3, hex2, hex1, hex0}, e.hex);
        chk({t, ".led"},   ledg,      e.led);
        chk({t, ".pulse"}, min_pulse, e.pulse);
    endtask

    task automatic model_tick(input bit btn);
        exp_pulse = 1'b0;
        if (run) begin
            ss++;
            if (ss == 60) begin
                ss = 0;
                exp_pulse = 1'b1;
                mm++;
                if (mm > 59) mm = 0;
            end
        end
        if (btn) run = !run;
    endtask

    task automatic do_reset(input string t);
        key = 1'b1; tick = 1'b0; run_btn = 1'b0;
        mm = 0; ss = 0; run = 1'b1; exp_pulse = 1'b0;
        push_exp(t);
        repeat (2) @(negedge clk);
        key = 1'b0;
        pop_cmp();
    endtask

    task automatic do_tick(input string t, input int gap);
        tick = 1'b1;
        model_tick(1'b0);
        push_exp(t);
        @(negedge clk);
        tick = 1'b0;
        pop_cmp();
        @(negedge clk);
        chk({t, ".pulse_off"}, min_pulse, 1'b0);
        repeat (gap) @(negedge clk);
    endtask

    task automatic press_btn(input string t);
        bit old;
        old = run;
        run_btn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk({t, ".led_k1"}, ledg, old);
        run = !run; exp_pulse = 1'b0;
        push_exp(t);
        @(negedge clk);
        run_btn = 1'b0;
        pop_cmp();
        repeat (3) @(negedge clk);
    endtask

    task automatic tick_and_btn(input string t);
        run_btn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tick = 1'b1;
        model_tick(1'b1);
        push_exp(t);
        @(negedge clk);
        tick = 1'b0; run_btn = 1'b0;
        pop_cmp();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        key2 = 1'b1; tick2 = 1'b0; btn2 = 1'b0;

        do_reset("reset");

        for (int i = 0; i < 5; i++) do_tick("tick5", 8);

        tick = 1'b1;
        model_tick(1'b0);
        push_exp("hold");
        repeat (20) @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        pop_cmp();

        do_reset("reset_mid");
        for (int i = 0; i < 59; i++) do_tick("pre59", 0);
        do_tick("to_0100", 2);
        while (!(mm == 59 && ss == 59)) do_tick("bulk", 0);
        do_tick("wrap", 2);

        for (int i = 0; i < 7; i++) do_tick("to_0007", 0);
        tick_and_btn("both_run");
        for (int i = 0; i < 10; i++) do_tick("stopped", 0);
        tick_and_btn("both_stop");
        do_tick("after_resume", 2);
        press_btn("pause");
        do_tick("paused_tick", 2);
        press_btn("resume");
        do_tick("resumed_tick", 2);

        while (!(mm == 12 && ss == 34)) do_tick("to_1234", 0);
        run_btn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        key = 1'b1; tick = 1'b1;
        mm = 0; ss = 0; run = 1'b1; exp_pulse = 1'b0;
        push_exp("reset_all");
        @(negedge clk);
        key = 1'b0; tick = 1'b0; run_btn = 1'b0;
        pop_cmp();
        push_exp("after_reset");
        repeat (4) @(negedge clk);
        pop_cmp();

        key2 = 1'b0;
        @(negedge clk);
        chk("stop_rst.led", ledg2, 1'b0);
        chk("stop_rst.hex", {h2_3, h2_2, h2_1, h2_0}, hex_of(0, 0));
        for (int i = 0; i < 3; i++) begin
            tick2 = 1'b1; @(negedge clk);
            tick2 = 1'b0; @(negedge clk);
        end
        chk("stop_ticks.hex", {h2_3, h2_2, h2_1, h2_0}, hex_of(0, 0));
        chk("stop_ticks.pulse", mp2, 1'b0);
        btn2 = 1'b1;
        repeat (3) @(negedge clk);
        btn2 = 1'b0;
        chk("stop_btn.led", ledg2, 1'b1);
        tick2 = 1'b1; @(negedge clk);
        tick2 = 1'b0; @(negedge clk);
        chk("stop_run.hex", {h2_3, h2_2, h2_1, h2_0}, hex_of(0, 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
